// File: rtl/bcd_alu_pkg.sv
// Shared definitions for the BCD ALU: digit width, operation encodings and FSM states.
package bcd_alu_pkg;
    localparam int DIGIT_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_POW = 3'b100;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        ADDSUB,
        MUL_SHIFT,
        MUL_ADD,
        DIV_SHIFT,
        DIV_SUB,
        POW_LOOP,
        FINISH
    } state_t;
endpackage

// File: rtl/bcd_addsub.sv
// Combinational multi-digit BCD adder/subtractor; cout is the carry (add) or borrow (sub) out of the MSD.
module bcd_addsub
    import bcd_alu_pkg::*;
#(
    parameter int DIGITS = 4,
    localparam int W = DIGIT_W * DIGITS
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y,
    output logic         cout
);
    logic       c;
    logic [4:0] t;

    always_comb begin
        c = 1'b0;
        t = '0;
        y = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sub) begin
                t = {1'b0, a[i*DIGIT_W +: DIGIT_W]} - {1'b0, b[i*DIGIT_W +: DIGIT_W]} - {4'b0, c};
                c = t[4];
                // a wrapped nibble is 6 above the decimal wrap, so pull it back down
                if (c) t = t - 5'd6;
            end else begin
                t = {1'b0, a[i*DIGIT_W +: DIGIT_W]} + {1'b0, b[i*DIGIT_W +: DIGIT_W]} + {4'b0, c};
                c = (t > 5'd9);
                if (c) t = t + 5'd6;
            end
            y[i*DIGIT_W +: DIGIT_W] = t[3:0];
        end
        cout = c;
    end
endmodule

// File: rtl/bcd_alu_seq.sv
// Multi-cycle unsigned BCD ALU (add, sub, mul, div, pow) with start/busy/done handshake and err flag.
// Power is built only when the BCD_ALU_POW_EN macro is defined; otherwise op 100 reports err.
module bcd_alu_seq
    import bcd_alu_pkg::*;
#(
    parameter int DIGITS = 4,
    localparam int W = DIGIT_W * DIGITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] num1,
    input  logic [W-1:0] num2,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] res,
    output logic         err
);
    localparam int IW = $clog2(DIGITS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS);

    state_t         state;
    logic [2:0]     op_r;
    logic [W-1:0]   a, b, acc, rem, scan;
    logic [3:0]     rem_hi, dcnt;
    logic [IW-1:0]  idx;

    logic [W-1:0]   as_x, as_y, as_out;
    logic           as_sub, as_c;
    logic           digits_ok, op_ok;

    always_comb begin
        as_x   = a;
        as_y   = b;
        as_sub = 1'b0;
        case (state)
            ADDSUB:  as_sub = (op_r == OP_SUB);
            MUL_ADD: begin as_x = acc; as_y = a; end
            DIV_SUB: begin as_x = rem; as_sub = 1'b1; end
            default: ;
        endcase
    end

    bcd_addsub #(.DIGITS(DIGITS)) u_addsub (
        .a    (as_x),
        .b    (as_y),
        .sub  (as_sub),
        .y    (as_out),
        .cout (as_c)
    );

    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (a[i*DIGIT_W +: DIGIT_W] > 4'd9 || b[i*DIGIT_W +: DIGIT_W] > 4'd9)
                digits_ok = 1'b0;
    end

`ifdef BCD_ALU_POW_EN
    logic [W-1:0] cnt_dec;
    logic         dec_brw;

    // b doubles as the BCD exponent counter during pow
    always_comb begin
        cnt_dec = b;
        dec_brw = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (dec_brw) begin
                if (b[i*DIGIT_W +: DIGIT_W] == 4'd0) begin
                    cnt_dec[i*DIGIT_W +: DIGIT_W] = 4'd9;
                end else begin
                    cnt_dec[i*DIGIT_W +: DIGIT_W] = b[i*DIGIT_W +: DIGIT_W] - 4'd1;
                    dec_brw = 1'b0;
                end
            end
        end
    end

    assign op_ok = (op_r <= OP_POW);
`else
    assign op_ok = (op_r < OP_POW);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_r   <= '0;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            rem    <= '0;
            scan   <= '0;
            rem_hi <= '0;
            dcnt   <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            res    <= '0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_r  <= op;
                    a     <= num1;
                    b     <= num2;
                    busy  <= 1'b1;
                    state <= CHECK;
                end
                CHECK: begin
                    acc    <= '0;
                    rem    <= '0;
                    rem_hi <= '0;
                    idx    <= '0;
                    scan   <= b;
                    if (!digits_ok || !op_ok || (op_r == OP_DIV && b == '0)) begin
                        state <= FINISH; done <= 1'b1; res <= '0; err <= 1'b1;
                    end else begin
                        case (op_r)
                            OP_ADD, OP_SUB: state <= ADDSUB;
                            OP_MUL:         state <= MUL_SHIFT;
                            OP_DIV:         state <= DIV_SHIFT;
                            default: begin
`ifdef BCD_ALU_POW_EN
                                rem   <= W'(1);
                                state <= POW_LOOP;
`else
                                state <= FINISH; done <= 1'b1; res <= '0; err <= 1'b1;
`endif
                            end
                        endcase
                    end
                end
                ADDSUB: begin
                    state <= FINISH;
                    done  <= 1'b1;
                    res   <= as_c ? '0 : as_out;
                    err   <= as_c;
                end
                MUL_SHIFT: begin
                    if (idx == LAST_IDX) begin
`ifdef BCD_ALU_POW_EN
                        if (op_r == OP_POW) begin
                            rem   <= acc;
                            state <= POW_LOOP;
                        end else begin
                            state <= FINISH; done <= 1'b1; res <= acc; err <= 1'b0;
                        end
`else
                        state <= FINISH; done <= 1'b1; res <= acc; err <= 1'b0;
`endif
                    end else if (acc[W-1 -: DIGIT_W] != 4'd0) begin
                        state <= FINISH; done <= 1'b1; res <= '0; err <= 1'b1;
                    end else begin
                        acc   <= acc << DIGIT_W;
                        scan  <= scan << DIGIT_W;
                        dcnt  <= scan[W-1 -: DIGIT_W];
                        idx   <= idx + 1'b1;
                        state <= (scan[W-1 -: DIGIT_W] == 4'd0) ? MUL_SHIFT : MUL_ADD;
                    end
                end
                MUL_ADD: begin
                    if (as_c) begin
                        state <= FINISH; done <= 1'b1; res <= '0; err <= 1'b1;
                    end else begin
                        acc  <= as_out;
                        dcnt <= dcnt - 4'd1;
                        if (dcnt == 4'd1) state <= MUL_SHIFT;
                    end
                end
                DIV_SHIFT: begin
                    if (idx == LAST_IDX) begin
                        state <= FINISH; done <= 1'b1; res <= acc; err <= 1'b0;
                    end else begin
                        // the partial remainder can briefly need one digit more than W
                        rem_hi <= rem[W-1 -: DIGIT_W];
                        rem    <= (rem << DIGIT_W) | W'(a[W-1 -: DIGIT_W]);
                        a      <= a << DIGIT_W;
                        acc    <= acc << DIGIT_W;
                        idx    <= idx + 1'b1;
                        state  <= DIV_SUB;
                    end
                end
                DIV_SUB: begin
                    if (rem_hi != 4'd0 || !as_c) begin
                        rem      <= as_out;
                        rem_hi   <= rem_hi - {3'b0, as_c};
                        acc[3:0] <= acc[3:0] + 4'd1;
                    end else begin
                        state <= DIV_SHIFT;
                    end
                end
`ifdef BCD_ALU_POW_EN
                POW_LOOP: begin
                    if (b == '0) begin
                        state <= FINISH; done <= 1'b1; res <= rem; err <= 1'b0;
                    end else begin
                        b     <= cnt_dec;
                        scan  <= rem;
                        acc   <= '0;
                        idx   <= '0;
                        state <= MUL_SHIFT;
                    end
                end
`endif
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_alu_seq.sv
// Self-checking bench for bcd_alu_seq: directed vectors, randomized ops against an integer model, handshake and reset.
module tb_bcd_alu_seq;
    localparam logic [2:0] T_ADD = 3'b000;
    localparam logic [2:0] T_SUB = 3'b001;
    localparam logic [2:0] T_MUL = 3'b010;
    localparam logic [2:0] T_DIV = 3'b011;
    localparam logic [2:0] T_POW = 3'b100;

    logic        clk;
    logic        rst;
    logic        start, busy, done, err;
    logic [2:0]  op;
    logic [15:0] num1, num2, res;
    logic        start6, busy6, done6, err6;
    logic [2:0]  op6;
    logic [23:0] n16, n26, res6;

    int checks = 0;
    int errors = 0;

    bcd_alu_seq #(.DIGITS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .num1(num1), .num2(num2),
        .busy(busy), .done(done), .res(res), .err(err)
    );

    bcd_alu_seq #(.DIGITS(6)) u_dut6 (
        .clk(clk), .rst(rst), .start(start6), .op(op6), .num1(n16), .num2(n26),
        .busy(busy6), .done(done6), .res(res6), .err(err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit bcd_ok(input logic [23:0] v, input int nd);
        for (int i = 0; i < nd; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic longint bcd2int(input logic [23:0] v, input int nd);
        longint s;
        s = 0;
        for (int i = nd - 1; i >= 0; i--) s = s * 10 + longint'(v[4*i +: 4]);
        return s;
    endfunction

    function automatic logic [23:0] int2bcd(input longint x);
        logic [23:0] v;
        longint t;
        v = '0;
        t = x;
        for (int i = 0; i < 6; i++) begin
            v[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return v;
    endfunction

    function automatic logic [15:0] rand_bcd(input int nd);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < nd; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Reference: plain decimal arithmetic on 4-digit values, plus the latency window the unit may take.
    function automatic void model(input logic [2:0] o, input logic [15:0] n1, input logic [15:0] n2,
                                  output logic [15:0] r, output logic e, output int lmin, output int lmax);
        longint x, y, p, lim;
        bit ok;
        int dsum;
        lim = 10000;
        r = '0; e = 1'b1; lmin = 2; lmax = 2;
        if (!bcd_ok({8'h0, n1}, 4) || !bcd_ok({8'h0, n2}, 4)) return;
        x = bcd2int({8'h0, n1}, 4);
        y = bcd2int({8'h0, n2}, 4);
        case (o)
            T_ADD: begin
                lmin = 3; lmax = 3;
                if (x + y < lim) begin e = 1'b0; r = 16'(int2bcd(x + y)); end
            end
            T_SUB: begin
                lmin = 3; lmax = 3;
                if (x >= y) begin e = 1'b0; r = 16'(int2bcd(x - y)); end
            end
            T_MUL: begin
                lmin = 3; lmax = 3 + 10 * 4;
                if (x * y < lim) begin
                    dsum = 0;
                    for (int i = 0; i < 4; i++) dsum += int'(n2[4*i +: 4]);
                    e = 1'b0; r = 16'(int2bcd(x * y));
                    lmin = 3 + 4 + dsum; lmax = lmin;
                end
            end
            T_DIV: begin
                if (y != 0) begin e = 1'b0; r = 16'(int2bcd(x / y)); lmin = 3; lmax = 3 + 11 * 4; end
            end
`ifdef BCD_ALU_POW_EN
            T_POW: begin
                p = 1; ok = 1'b1;
                for (longint i = 0; i < y; i++) begin
                    p = p * x;
                    if (p >= lim) begin ok = 1'b0; break; end
                end
                lmin = 3; lmax = 3 + int'(y) * (10 * 4 + 1);
                if (ok) begin e = 1'b0; r = 16'(int2bcd(p)); end
            end
`endif
            default: ;
        endcase
    endfunction

    // Issue one op on the 4-digit unit; scrambles the operand inputs right after acceptance.
    task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                          output logic [15:0] r, output logic e, output int lat);
        @(negedge clk);
        op = o; num1 = x; num2 = y; start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                op = 3'($urandom); num1 = 16'($urandom); num2 = 16'($urandom);
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL busy_cycle1 op=%0d got %b want 1", o, busy);
                end
            end
        end while (done !== 1'b1 && lat < 2000);
        r = res; e = err;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL done_seen op=%0d done=%b busy=%b after %0d cycles", o, done, busy, lat);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL after_done op=%0d busy=%b done=%b want 0 0", o, busy, done);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, err, res} !== 19'd0) begin
            errors++; $display("FAIL reset_outputs got busy=%b done=%b err=%b res=%h want all 0", busy, done, err, res);
        end
        checks++;
        if ({busy6, done6, err6, res6} !== 27'd0) begin
            errors++; $display("FAIL reset_outputs6 got busy=%b done=%b err=%b res=%h", busy6, done6, err6, res6);
        end
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [15:0] x, y, r;
        logic        e;
        int          lmin, lmax;
    } vec_t;

    task automatic test_directed();
        vec_t v[$];
        logic [15:0] r;
        logic e;
        int lat;
        v.push_back('{T_ADD, 16'h5000, 16'h4000, 16'h9000, 1'b0, 3, 3});
        v.push_back('{T_ADD, 16'h5000, 16'h5000, 16'h0000, 1'b1, 3, 3});
        v.push_back('{T_SUB, 16'h9999, 16'h8999, 16'h1000, 1'b0, 3, 3});
        v.push_back('{T_SUB, 16'h9999, 16'h9999, 16'h0000, 1'b0, 3, 3});
        v.push_back('{T_SUB, 16'h0007, 16'h0014, 16'h0000, 1'b1, 3, 3});
        v.push_back('{T_MUL, 16'h0010, 16'h0010, 16'h0100, 1'b0, 8, 8});
        v.push_back('{T_MUL, 16'h0002, 16'h1000, 16'h2000, 1'b0, 8, 8});
        v.push_back('{T_MUL, 16'h0200, 16'h0500, 16'h0000, 1'b1, 3, 43});
        v.push_back('{T_DIV, 16'h0014, 16'h0007, 16'h0002, 1'b0, 3, 47});
        v.push_back('{T_DIV, 16'h0016, 16'h0007, 16'h0002, 1'b0, 3, 47});
        v.push_back('{T_DIV, 16'h0008, 16'h0000, 16'h0000, 1'b1, 2, 2});
        v.push_back('{3'b101, 16'h0001, 16'h0001, 16'h0000, 1'b1, 2, 2});
        v.push_back('{T_ADD, 16'h00A0, 16'h0001, 16'h0000, 1'b1, 2, 2});
`ifdef BCD_ALU_POW_EN
        v.push_back('{T_POW, 16'h0004, 16'h0002, 16'h0016, 1'b0, 3, 85});
        v.push_back('{T_POW, 16'h0008, 16'h0000, 16'h0001, 1'b0, 3, 3});
`else
        v.push_back('{T_POW, 16'h0004, 16'h0002, 16'h0000, 1'b1, 2, 2});
        v.push_back('{T_POW, 16'h0008, 16'h0000, 16'h0000, 1'b1, 2, 2});
`endif
        foreach (v[i]) begin
            run_op(v[i].o, v[i].x, v[i].y, r, e, lat);
            checks++;
            if (r !== v[i].r || e !== v[i].e) begin
                errors++;
                $display("FAIL directed_%0d op=%0d %h,%h got res=%h err=%b want res=%h err=%b",
                         i, v[i].o, v[i].x, v[i].y, r, e, v[i].r, v[i].e);
            end
            checks++;
            if (lat < v[i].lmin || lat > v[i].lmax) begin
                errors++;
                $display("FAIL directed_lat_%0d got L=%0d want %0d..%0d", i, lat, v[i].lmin, v[i].lmax);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [15:0] x, y, r, er;
        logic        e, ee;
        int          lat, lmin, lmax, k;
        for (int i = 0; i < 80; i++) begin
            o = (i % 19 == 7) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            x = rand_bcd($urandom_range(1, 4));
            y = rand_bcd($urandom_range(1, 4));
            if (o == T_POW) y = 16'($urandom_range(0, 4));
            if (i % 11 == 3) begin
                k = $urandom_range(0, 3);
                x[4*k +: 4] = 4'($urandom_range(10, 15));
            end
            model(o, x, y, er, ee, lmin, lmax);
            run_op(o, x, y, r, e, lat);
            checks++;
            if (r !== er || e !== ee) begin
                errors++;
                $display("FAIL random_%0d op=%0d %h,%h got res=%h err=%b want res=%h err=%b", i, o, x, y, r, e, er, ee);
            end
            checks++;
            if (lat < lmin || lat > lmax) begin
                errors++;
                $display("FAIL random_lat_%0d op=%0d %h,%h got L=%0d want %0d..%0d", i, o, x, y, lat, lmin, lmax);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        @(negedge clk);
        op = T_MUL; num1 = 16'h0003; num2 = 16'h0009; start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (n == 3) begin start = 1'b1; op = T_ADD; num1 = 16'h0001; num2 = 16'h0001; end
            if (n == 4) start = 1'b0;
        end while (done !== 1'b1 && n < 200);
        checks++;
        if (res !== 16'h0027 || err !== 1'b0 || n != 16) begin
            errors++; $display("FAIL busy_ignore got res=%h err=%b L=%0d want 0027 0 16", res, err, n);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_ignore_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok1, ok2;
        @(negedge clk);
        op = T_ADD; num1 = 16'h0001; num2 = 16'h0002; start = 1'b1;
        n = 0; ok1 = 1'b0; ok2 = 1'b0;
        repeat (7) begin
            @(negedge clk);
            n++;
            if (n == 1) begin num1 = 16'h0005; num2 = 16'h0005; end
            if (n == 3 && done === 1'b1 && res === 16'h0003) ok1 = 1'b1;
            if (n == 4 && busy !== 1'b0) ok1 = 1'b0;
            if (n == 5) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL retrigger_busy got busy=%b want 1", busy);
                end
                start = 1'b0;
            end
            if (n == 7 && done === 1'b1 && res === 16'h0010 && err === 1'b0) ok2 = 1'b1;
        end
        checks++;
        if (!ok1 || !ok2) begin
            errors++; $display("FAIL back_to_back got first_ok=%0d second_ok=%0d want 1 1", ok1, ok2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        logic e;
        int lat, dones;
        @(negedge clk);
        op = T_DIV; num1 = 16'h9999; num2 = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, res} !== 19'd0) begin
            errors++; $display("FAIL reset_mid_outputs got busy=%b done=%b err=%b res=%h want all 0", busy, done, err, res);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL reset_mid_quiet got %0d active cycles want 0", dones);
        end
        run_op(T_ADD, 16'h0001, 16'h0002, r, e, lat);
        checks++;
        if (r !== 16'h0003 || e !== 1'b0) begin
            errors++; $display("FAIL reset_mid_next got res=%h err=%b want 0003 0", r, e);
        end
    endtask

    task automatic test_digits6();
        logic [23:0] a6[2], b6[2], r6[2];
        logic        e6[2];
        int n;
        a6[0] = 24'h999999; b6[0] = 24'h000001; r6[0] = 24'h000000; e6[0] = 1'b1;
        a6[1] = 24'h123456; b6[1] = 24'h654321; r6[1] = 24'h777777; e6[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            op6 = T_ADD; n16 = a6[i]; n26 = b6[i]; start6 = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
                start6 = 1'b0;
            end while (done6 !== 1'b1 && n < 100);
            checks++;
            if (res6 !== r6[i] || err6 !== e6[i] || n != 3) begin
                errors++;
                $display("FAIL digits6_%0d got res=%h err=%b L=%0d want res=%h err=%b L=3", i, res6, err6, n, r6[i], e6[i]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; op = '0; num1 = '0; num2 = '0;
        start6 = 1'b0; op6 = '0; n16 = '0; n26 = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_digits6();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_alu_seq.md
# bcd_alu_seq

Parametrised, multi-cycle unsigned BCD arithmetic unit. It is the successor to the team's fixed 4-digit calculator ALU, with configurable digit count, a start/busy/done handshake and an error flag. It sits between the keypad/operand registers and the display driver of the calculator. Add/sub complete in one compute cycle; mul, div and pow run iteratively digit by digit.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand and result; W = 4*DIGITS.
- `clk` in 1: single system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only while `busy`=0.
- `op` in 3: 000 add, 001 sub, 010 mul, 011 div (quotient), 100 pow; others invalid.
- `num1` in W: BCD operand A, least-significant digit in bits [3:0].
- `num2` in W: BCD operand B.
- `busy` out 1: high from the cycle after an accepted `start` until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse; `res`/`err` are valid from this cycle onward.
- `res` out W: BCD result, held until the next `done`.
- `err` out 1: overflow, negative difference, divide by zero, invalid op or invalid BCD digit; held with `res`.

## Operation
- FSM states: IDLE, CHECK, ADDSUB, MUL_SHIFT, MUL_ADD, DIV_SHIFT, DIV_SUB, POW_LOOP, FINISH.
- IDLE: `start`=1 latches `op`, `num1` and `num2`, then goes to CHECK.
- CHECK: any digit >9, or an invalid op, leads to FINISH with err=1, res=0.
  - div with num2=0 leads to FINISH with err=1, res=0.
  - Otherwise the FSM dispatches by op.
- ADDSUB:
  - add: a carry out of the MSD sets err=1, res=0.
  - sub: num1<num2 (borrow out) sets err=1, res=0.
  - Then FINISH.
- mul, shift-and-add, num2 scanned MSD first, for each digit:
  - MUL_SHIFT: acc <<= 1 digit. A non-zero digit shifted out sets overflow.
  - MUL_ADD: acc += num1, repeated d times. A carry out sets overflow.
- div, restoring, num1 scanned MSD first, for each digit:
  - DIV_SHIFT: rem = rem*10 + next digit.
  - DIV_SUB: subtract num2 while rem≥num2, counting into the quotient digit (0..9).
  - Quotient is truncated; the remainder is discarded.
- pow:
  - acc=1, cnt=num2.
  - POW_LOOP: while cnt≠0, acc = acc*num1 using the mul sequence, then cnt--.
  - 0^0 = 1. Any overflow aborts immediately with err=1, res=0.
- FINISH: drive `res`/`err`, pulse `done`, return to IDLE.
- Once overflow is flagged, the FSM skips to FINISH at the next state boundary.

## Timing
- Reset values: busy=0, done=0, res=0, err=0, FSM=IDLE, all internal registers 0.
- `start` is accepted at cycle 0. `busy`=1 from cycle 1. `done`=1 at cycle L; `busy` drops at L+1.
- `start` is ignored while busy; `start` held high re-triggers at the first IDLE cycle after done.
- Operand changes after acceptance have no effect.
- Latency L:
  - Error detected in CHECK: L=2.
  - add/sub: L=3.
  - mul: L = 3 + DIGITS + Σ(num2 digits); max 3+10·DIGITS.
  - div: L ≤ 3 + 11·DIGITS.
  - pow: L ≤ 3 + num2_binary·(10·DIGITS+1). Unbounded num2 is allowed, because the overflow abort bounds it in practice.
- Reset asserted mid-operation aborts asynchronously. No `done` is produced, and outputs return to reset values.

## Configuration
- `BCD_ALU_POW_EN`:
  - Defined: op 100 computes the power as above.
  - Undefined: POW_LOOP is not built; op 100 is treated as invalid (err=1, res=0, L=2).

## Structure
- Shared package `bcd_alu_pkg`:
  - op encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_POW);
  - FSM state enum;
  - digit-width constant (4).
- Sub-module `bcd_addsub`: combinational W-bit BCD adder/subtractor with per-digit +6 correction, carry/borrow out, and a `sub` select. It is shared by ADDSUB, MUL_ADD and DIV_SUB.

## Test plan
- DIGITS=4, add: 5000+4000 → res=9000, err=0, done at L=3. 5000+5000 → err=1, res=0000.
- sub: 9999−8999 → 1000. 9999−9999 → 0000. 0007−0014 → err=1.
- mul: 0010·0010 → 0100. 0002·1000 → 2000. 0200·0500 → err=1 (overflow).
- div: 0014/0007 → 0002. 0016/0007 → 0002. 0008/0000 → err=1 at L=2.
- pow (macro defined): 0004^0002 → 0016; 0008^0000 → 0001. Macro undefined: op 100 → err=1.
- Control:
  - `start` during busy is ignored.
  - `rst` pulse in the middle of a 9999/0001 divide → no done, outputs 0; the next start works.
  - DIGITS=6: 999999+000001 → err=1.
